// File: rtl/alsu.sv
// Registered 3-bit arithmetic/logic/shift unit: inputs are captured, evaluated, then registered again.
// Invalid requests clear the result and blink the LED bank every cycle.
module alsu #(
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    input  logic [2:0]  opcode,
    input  logic        cin,
    input  logic        serial_in,
    input  logic        direction,
    input  logic        red_op_A,
    input  logic        red_op_B,
    input  logic        bypass_A,
    input  logic        bypass_B,
    output logic [5:0]  out,
    output logic [15:0] leds
);

    localparam int unsigned OPNDW = 3;
    localparam int unsigned OUTW  = 6;
    localparam int unsigned LEDW  = 16;
    localparam bit          PRIO_A = (INPUT_PRIORITY != "B");
    localparam bit          FA_ON  = (FULL_ADDER == "ON");

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_XOR    = 3'b001,
        OP_ADD    = 3'b010,
        OP_MULT   = 3'b011,
        OP_SHIFT  = 3'b100,
        OP_ROTATE = 3'b101,
        OP_RSVD6  = 3'b110,
        OP_RSVD7  = 3'b111
    } op_e;

    logic [OPNDW-1:0] a_q, b_q;
    op_e              opcode_q;
    logic             cin_q, serial_q, dir_q;
    logic             red_a_q, red_b_q, byp_a_q, byp_b_q;
    logic [OUTW-1:0]  out_q, out_d;
    logic [LEDW-1:0]  leds_q, leds_d;
    logic             red_a, red_b, invalid;

    // Input capture stage and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= OP_AND;
            cin_q    <= 1'b0;
            serial_q <= 1'b0;
            dir_q    <= 1'b0;
            red_a_q  <= 1'b0;
            red_b_q  <= 1'b0;
            byp_a_q  <= 1'b0;
            byp_b_q  <= 1'b0;
            out_q    <= '0;
            leds_q   <= '0;
        end else begin
            a_q      <= A;
            b_q      <= B;
            opcode_q <= op_e'(opcode);
            cin_q    <= cin;
            serial_q <= serial_in;
            dir_q    <= direction;
            red_a_q  <= red_op_A;
            red_b_q  <= red_op_B;
            byp_a_q  <= bypass_A;
            byp_b_q  <= bypass_B;
            out_q    <= out_d;
            leds_q   <= leds_d;
        end
    end

    // Evaluation from registered inputs: bypass, then invalid, then opcode
    always_comb begin
        out_d   = '0;
        leds_d  = '0;
        red_a   = red_a_q & (~red_b_q | PRIO_A);
        red_b   = red_b_q & ~red_a;
        invalid = (opcode_q == OP_RSVD6) || (opcode_q == OP_RSVD7) ||
                  ((red_a_q | red_b_q) && (opcode_q != OP_AND) && (opcode_q != OP_XOR));

        if (byp_a_q | byp_b_q) begin
            out_d = (byp_a_q && (!byp_b_q || PRIO_A)) ? OUTW'(a_q) : OUTW'(b_q);
        end else if (invalid) begin
            leds_d = ~leds_q;
        end else begin
            case (opcode_q)
                OP_AND:    out_d = red_a ? OUTW'(&a_q) : (red_b ? OUTW'(&b_q) : OUTW'(a_q & b_q));
                OP_XOR:    out_d = red_a ? OUTW'(^a_q) : (red_b ? OUTW'(^b_q) : OUTW'(a_q ^ b_q));
                OP_ADD:    out_d = OUTW'(a_q) + OUTW'(b_q) + OUTW'(cin_q & FA_ON);
                OP_MULT:   out_d = OUTW'(a_q) * OUTW'(b_q);
                OP_SHIFT:  out_d = dir_q ? {out_q[OUTW-2:0], serial_q} : {serial_q, out_q[OUTW-1:1]};
                OP_ROTATE: out_d = dir_q ? {out_q[OUTW-2:0], out_q[OUTW-1]} : {out_q[0], out_q[OUTW-1:1]};
                default:   out_d = '0;
            endcase
        end
    end

    assign out  = out_q;
    assign leds = leds_q;

endmodule

// File: tb/tb_alsu.sv
// Scoreboard bench for alsu: two instances (priority A / full adder ON, priority B / adder OFF)
// share stimulus; expected results come from an arithmetic reference model.
module tb_alsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  a_in = '0, b_in = '0, op_in = '0;
    logic        cin_in = 1'b0, si_in = 1'b0, dir_in = 1'b0;
    logic        ra_in = 1'b0, rb_in = 1'b0, ba_in = 1'b0, bb_in = 1'b0;
    logic [5:0]  out_a, out_b;
    logic [15:0] leds_a, leds_b;

    always #5 clk = ~clk;

    alsu #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut_a (
        .clk(clk), .rst(rst), .A(a_in), .B(b_in), .opcode(op_in), .cin(cin_in),
        .serial_in(si_in), .direction(dir_in), .red_op_A(ra_in), .red_op_B(rb_in),
        .bypass_A(ba_in), .bypass_B(bb_in), .out(out_a), .leds(leds_a)
    );

    alsu #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut_b (
        .clk(clk), .rst(rst), .A(a_in), .B(b_in), .opcode(op_in), .cin(cin_in),
        .serial_in(si_in), .direction(dir_in), .red_op_A(ra_in), .red_op_B(rb_in),
        .bypass_A(ba_in), .bypass_B(bb_in), .out(out_b), .leds(leds_b)
    );

    typedef struct {
        string tag;
        int    oa;
        int    la;
        int    ob;
        int    lb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_oa = 0, m_la = 0, m_ob = 0, m_lb = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: out value and led pattern after one evaluation
    function automatic void model(input bit prio_a, input bit fa_on, input int a, input int b,
                                  input int op, input int ci, input int si, input int dir,
                                  input int ra, input int rb, input int ba, input int bb,
                                  inout int o, inout int l);
        bit use_a, use_b;
        use_a = (ra != 0) && ((rb == 0) || prio_a);
        use_b = (rb != 0) && !use_a;
        if (ba != 0 || bb != 0) begin
            if (ba != 0 && bb != 0) o = prio_a ? a : b;
            else                    o = (ba != 0) ? a : b;
            l = 0;
        end else if (op >= 6 || ((ra != 0 || rb != 0) && op > 1)) begin
            o = 0;
            l = 65535 - l;
        end else begin
            l = 0;
            case (op)
                0: o = use_a ? int'(a == 7) : (use_b ? int'(b == 7) : (a & b));
                1: o = use_a ? $countones(a) % 2 : (use_b ? $countones(b) % 2 : (a ^ b));
                2: o = a + b + (fa_on ? ci : 0);
                3: o = a * b;
                4: o = (dir != 0) ? (o * 2) % 64 + si : si * 32 + o / 2;
                default: o = (dir != 0) ? (o * 2) % 64 + o / 32 : (o % 2) * 32 + o / 2;
            endcase
        end
    endfunction

    task automatic drive_now(input string tag, input int a, input int b, input int op,
                             input int ci, input int si, input int dir,
                             input int ra, input int rb, input int ba, input int bb);
        a_in   = 3'(a);
        b_in   = 3'(b);
        op_in  = 3'(op);
        cin_in = 1'(ci);
        si_in  = 1'(si);
        dir_in = 1'(dir);
        ra_in  = 1'(ra);
        rb_in  = 1'(rb);
        ba_in  = 1'(ba);
        bb_in  = 1'(bb);
        model(1'b1, 1'b1, a, b, op, ci, si, dir, ra, rb, ba, bb, m_oa, m_la);
        model(1'b0, 1'b0, a, b, op, ci, si, dir, ra, rb, ba, bb, m_ob, m_lb);
        sb.push_back('{tag, m_oa, m_la, m_ob, m_lb});
    endtask

    task automatic apply(input string tag, input int a, input int b, input int op,
                         input int ci, input int si, input int dir,
                         input int ra, input int rb, input int ba, input int bb);
        @(negedge clk);
        drive_now(tag, a, b, op, ci, si, dir, ra, rb, ba, bb);
    endtask

    // Release reset; the first edge still evaluates the cleared input registers
    task automatic release_reset();
        @(negedge clk);
        rst  = 1'b1;
        m_oa = 0; m_la = 0; m_ob = 0; m_lb = 0;
        sb.push_back('{"post_reset", 0, 0, 0, 0});
        drive_now("rel_bypass", 5, 2, 3, 0, 0, 0, 0, 0, 1, 1);
    endtask

    // Monitor: one output per clock, compared in order against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "/out_A_ON"},   int'(out_a),  e.oa);
                check({e.tag, "/leds_A_ON"},  int'(leds_a), e.la);
                check({e.tag, "/out_B_OFF"},  int'(out_b),  e.ob);
                check({e.tag, "/leds_B_OFF"}, int'(leds_b), e.lb);
            end
        end
    end

    initial begin
        // Reset held across every control combination with random data
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            a_in = 3'($urandom); b_in = 3'($urandom);
            cin_in = 1'($urandom); si_in = 1'($urandom); dir_in = 1'($urandom);
            op_in = 3'(i); ra_in = 1'(i >> 3); rb_in = 1'(i >> 4);
            ba_in = 1'(i >> 5); bb_in = 1'(i >> 6);
            @(posedge clk);
            #1;
            check("rst_out_A",  int'(out_a),  0);
            check("rst_leds_A", int'(leds_a), 0);
            check("rst_out_B",  int'(out_b),  0);
            check("rst_leds_B", int'(leds_b), 0);
        end
        release_reset();

        //     tag          A  B  op cin si dir ra rb ba bb
        apply("byp_only_b", 5, 2, 3, 0, 0, 0, 0, 0, 0, 1);
        apply("red_and_a7", 7, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        apply("red_and_a6", 6, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        apply("red_xor_b3", 2, 3, 1, 0, 0, 0, 0, 1, 0, 0);
        apply("red_xor_b1", 2, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        apply("red_both",   7, 3, 0, 0, 0, 0, 1, 1, 0, 0);
        apply("and_plain",  6, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        apply("xor_plain",  6, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) apply("inv_op6", 3, 4, 6, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) apply("inv_red_add", 3, 4, 2, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) apply("leave_inv", 3, 4, 2, 0, 0, 0, 0, 0, 0, 0);
        apply("add_max",  7, 7, 2, 1, 0, 0, 0, 0, 0, 0);
        apply("mult_max", 7, 7, 3, 0, 0, 0, 0, 0, 0, 0);
        apply("preload3", 1, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) apply("shl_si1", 0, 0, 4, 0, 1, 1, 0, 0, 0, 0);
        apply("preload1", 1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) apply("shl_si0", 0, 0, 4, 0, 0, 1, 0, 0, 0, 0);
        apply("shl_to33", 0, 0, 4, 0, 1, 1, 0, 0, 0, 0);
        repeat (2) apply("rotr", 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) apply("rotl", 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) apply("shr_si1", 0, 0, 4, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) apply("inv_op7", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-blink clears outputs without waiting for a clock edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("async_rst_out_A",  int'(out_a),  0);
        check("async_rst_leds_A", int'(leds_a), 0);
        check("async_rst_out_B",  int'(out_b),  0);
        check("async_rst_leds_B", int'(leds_b), 0);
        repeat (2) @(posedge clk);
        release_reset();

        for (int i = 0; i < 400; i++) begin
            apply("random", int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(7)), int'($urandom_range(1)), int'($urandom_range(1)),
                  int'($urandom_range(1)), int'($urandom_range(3) == 0), int'($urandom_range(3) == 0),
                  int'($urandom_range(7) == 0), int'($urandom_range(7) == 0));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("drain_pending", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
